// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator: per-transfer divide, CPOL/CPHA and length; registered SCLK and edge/shift/sample/done strobes.
// Accept-to-done 1+(2N+1)*H cycles; start accepted only in IDLE/DONE, i_abort returns to IDLE next cycle.
module spi_sclk_gen #(
  parameter int DIV_W    = 8,
  parameter int MAX_BITS = 32,
  parameter int BITS_W   = $clog2(MAX_BITS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic [DIV_W-1:0]  i_half_div,
  input  logic [BITS_W-1:0] i_nbits,
  input  logic              i_start_valid,
  output logic              o_start_ready,
  input  logic              i_abort,
  output logic              o_sclk,
  output logic              o_busy,
  output logic              o_lead_edge,
  output logic              o_trail_edge,
  output logic              o_shift,
  output logic              o_sample,
  output logic [BITS_W-1:0] o_bit_idx,
  output logic              o_done
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_RUN, ST_HOLD, ST_DONE} state_t;

  localparam logic [DIV_W-1:0]  HC_ONE = DIV_W'(1);
  localparam logic [BITS_W-1:0] NB_ONE = BITS_W'(1);
  localparam logic [BITS_W-1:0] NB_MAX = BITS_W'(MAX_BITS);
  localparam logic [BITS_W:0]   EC_ONE = (BITS_W + 1)'(1);

  state_t              state_q, state_d;
  logic                cpol_q, cpha_q;
  logic [DIV_W-1:0]    half_q, hcnt_q;
  logic [BITS_W-1:0]   nbits_q, nbits_eff;
  logic [BITS_W:0]     ecnt_q, edge_num;
  logic                accept, active, hc_zero, edge_go, last_edge;
  logic                sclk_d, lead_d, trail_d, shift_d, sample_d, done_d;

  assign o_start_ready = !i_rst && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept        = i_start_valid && o_start_ready;
  assign active        = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign o_busy        = active;
  assign hc_zero       = (hcnt_q == '0);
  assign edge_go       = ((state_q == ST_SETUP) || (state_q == ST_RUN)) && hc_zero && !i_abort;
  assign edge_num      = ecnt_q + EC_ONE;
  assign last_edge     = (edge_num == {nbits_q, 1'b0});

  always_comb begin
    nbits_eff = i_nbits;
    if (i_nbits == '0)
      nbits_eff = NB_ONE;
    else if (i_nbits > NB_MAX)
      nbits_eff = NB_MAX;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: begin
        if (i_abort)      state_d = ST_IDLE;
        else if (hc_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_abort)                   state_d = ST_IDLE;
        else if (hc_zero && last_edge) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_abort)      state_d = ST_IDLE;
        else if (hc_zero) state_d = ST_DONE;
      end
      ST_DONE:  state_d = accept ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Odd edge numbers are leading edges; the final trailing edge launches no further bit.
  always_comb begin
    sclk_d   = o_sclk;
    lead_d   = 1'b0;
    trail_d  = 1'b0;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        sclk_d  = i_cpol;
        shift_d = accept && !i_cpha;
      end
      default: begin
        if (i_abort) begin
          sclk_d = cpol_q;
        end else if (edge_go) begin
          sclk_d  = ~o_sclk;
          lead_d  = edge_num[0];
          trail_d = ~edge_num[0];
          if (cpha_q) begin
            shift_d  = edge_num[0];
            sample_d = ~edge_num[0];
          end else begin
            sample_d = edge_num[0];
            shift_d  = ~edge_num[0] && !last_edge;
          end
        end else if (state_q == ST_HOLD && hc_zero) begin
          done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      half_q  <= '0;
      nbits_q <= NB_ONE;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
    end else if (accept) begin
      cpol_q  <= i_cpol;
      cpha_q  <= i_cpha;
      half_q  <= i_half_div;
      nbits_q <= nbits_eff;
      hcnt_q  <= i_half_div;
      ecnt_q  <= '0;
    end else if (active) begin
      hcnt_q <= hc_zero ? half_q : hcnt_q - HC_ONE;
      if (edge_go)
        ecnt_q <= edge_num;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sclk       <= 1'b0;
      o_lead_edge  <= 1'b0;
      o_trail_edge <= 1'b0;
      o_shift      <= 1'b0;
      o_sample     <= 1'b0;
      o_done       <= 1'b0;
      o_bit_idx    <= '0;
    end else begin
      o_sclk       <= sclk_d;
      o_lead_edge  <= lead_d;
      o_trail_edge <= trail_d;
      o_shift      <= shift_d;
      o_sample     <= sample_d;
      o_done       <= done_d;
      if (accept)
        o_bit_idx <= '0;
      else if (o_sample && o_bit_idx != nbits_q)
        o_bit_idx <= o_bit_idx + NB_ONE;
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: expected strobe events per transfer are queued at accept and matched by a monitor.
module tb_spi_sclk_gen;
  localparam int DIV_W    = 8;
  localparam int MAX_BITS = 32;
  localparam int BITS_W   = 6;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_cpol = 1'b0;
  logic              i_cpha = 1'b0;
  logic [DIV_W-1:0]  i_half_div = '0;
  logic [BITS_W-1:0] i_nbits = '0;
  logic              i_start_valid = 1'b0;
  logic              o_start_ready;
  logic              i_abort = 1'b0;
  logic              o_sclk, o_busy, o_lead_edge, o_trail_edge, o_shift, o_sample, o_done;
  logic [BITS_W-1:0] o_bit_idx;

  spi_sclk_gen #(.DIV_W(DIV_W), .MAX_BITS(MAX_BITS), .BITS_W(BITS_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cpol(i_cpol), .i_cpha(i_cpha),
    .i_half_div(i_half_div), .i_nbits(i_nbits),
    .i_start_valid(i_start_valid), .o_start_ready(o_start_ready), .i_abort(i_abort),
    .o_sclk(o_sclk), .o_busy(o_busy), .o_lead_edge(o_lead_edge), .o_trail_edge(o_trail_edge),
    .o_shift(o_shift), .o_sample(o_sample), .o_bit_idx(o_bit_idx), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         cyc;
    logic [4:0] strb;   // {lead, trail, shift, sample, done}
    logic       sclk;
    int         idx;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: edge k of a transfer lands k half-periods after SETUP starts; returns the o_done cycle.
  function automatic int push_xfer(input int t, input bit cpol, input bit cpha, input int hd, input int nb);
    int  h, n, smp;
    bit  lead, shf, smpl;
    ev_t e;
    h   = hd + 1;
    n   = (nb == 0) ? 1 : ((nb > MAX_BITS) ? MAX_BITS : nb);
    smp = 0;
    if (!cpha) begin
      e.cyc = t + 1; e.strb = 5'b00100; e.sclk = cpol; e.idx = 0;
      exp_q.push_back(e);
    end
    for (int k = 1; k <= 2 * n; k++) begin
      lead = (k % 2) == 1;
      shf  = cpha ? lead : (!lead && k != 2 * n);
      smpl = cpha ? !lead : lead;
      e.cyc  = t + 1 + k * h;
      e.strb = {lead, !lead, shf, smpl, 1'b0};
      e.sclk = lead ? !cpol : cpol;
      e.idx  = smp;
      exp_q.push_back(e);
      if (smpl) smp++;
    end
    e.cyc = t + 1 + (2 * n + 1) * h; e.strb = 5'b00001; e.sclk = cpol; e.idx = n;
    exp_q.push_back(e);
    return e.cyc;
  endfunction

  logic [4:0] obs;
  ev_t        got;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      obs = {o_lead_edge, o_trail_edge, o_shift, o_sample, o_done};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (obs != 5'b0) begin
        if (exp_q.size() == 0)
          chk("unexpected_strobes", obs, 0);
        else if (exp_q[0].cyc != cyc)
          chk("early_strobe_cycle", cyc, exp_q[0].cyc);
        else begin
          got = exp_q.pop_front();
          chk("strobes", obs, got.strb);
          chk("sclk_at_strobe", o_sclk, got.sclk);
          chk("bit_idx_at_strobe", o_bit_idx, got.idx);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  // Present a start; config is scrambled right after accept unless the start is held for a back-to-back.
  task automatic start_xfer(input bit cpol, input bit cpha, input int hd, input int nb,
                            input bit keep, input bit abrt, output int t, output int t_done);
    int n;
    @(negedge i_clk);
    i_cpol = cpol; i_cpha = cpha; i_half_div = hd[DIV_W-1:0]; i_nbits = nb[BITS_W-1:0];
    i_start_valid = 1'b1; i_abort = abrt;
    n = 0;
    while (!o_start_ready && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    t = cyc;
    if (!o_start_ready) begin
      chk("accept_timeout", 0, 1);
      t_done = cyc;
      i_start_valid = 1'b0;
      i_abort = 1'b0;
    end else begin
      t_done = push_xfer(t, cpol, cpha, hd, nb);
      @(negedge i_clk);
      i_abort = 1'b0;
      chk("busy_after_accept", o_busy, 1);
      chk("ready_after_accept", o_start_ready, 0);
      if (!keep) begin
        i_start_valid = 1'b0;
        i_cpol = ~cpol; i_cpha = ~cpha;
        i_half_div = DIV_W'($urandom); i_nbits = BITS_W'($urandom);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, td, t2, td2, c, e5;
  bit rc, rp;

  initial begin
    repeat (2) @(negedge i_clk);
    chk("reset_outputs",
        {o_sclk, o_busy, o_start_ready, o_lead_edge, o_trail_edge, o_shift, o_sample, o_done, o_bit_idx}, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_cpol = 1'b1;
    @(negedge i_clk);
    chk("idle_sclk_follows_cpol_hi", o_sclk, 1);
    i_cpol = 1'b0;
    @(negedge i_clk);
    chk("idle_sclk_follows_cpol_lo", o_sclk, 0);

    // Mode 0, H=4, N=8
    start_xfer(1'b0, 1'b0, 3, 8, 1'b0, 1'b0, t, td);
    wait_until(t + 5);
    chk("mode0_first_lead", o_lead_edge, 1);
    wait_until(t + 69);
    chk("mode0_done", o_done, 1);
    chk("mode0_done_busy", o_busy, 0);
    chk("mode0_done_ready", o_start_ready, 1);

    // Mode 3, H=1, N=32
    start_xfer(1'b1, 1'b1, 0, 32, 1'b0, 1'b0, t, td);
    wait_until(t + 66);
    chk("mode3_done", o_done, 1);
    chk("mode3_bit_idx", o_bit_idx, 32);

    // nbits=0 behaves as one SCLK cycle
    start_xfer(1'b0, 1'b1, 1, 0, 1'b0, 1'b0, t, td);
    wait_until(t + 1 + 3 * 2);
    chk("nbits0_done", o_done, 1);

    // nbits=40 clamps to 32
    start_xfer(1'b0, 1'b1, 0, 40, 1'b0, 1'b0, t, td);
    wait_until(t + 66);
    chk("nbits40_done", o_done, 1);
    chk("nbits40_bit_idx", o_bit_idx, 32);

    // Maximum half-period
    start_xfer(1'b1, 1'b0, 255, 1, 1'b0, 1'b0, t, td);
    wait_until(t + 256);
    chk("div256_sclk_before_edge", o_sclk, 1);
    @(negedge i_clk);
    chk("div256_first_lead", o_lead_edge, 1);
    wait_until(t + 769);
    chk("div256_done", o_done, 1);

    // Back-to-back with a different config held on the start request
    start_xfer(1'b0, 1'b0, 1, 3, 1'b1, 1'b0, t, td);
    start_xfer(1'b1, 1'b1, 2, 5, 1'b0, 1'b0, t2, td2);
    chk("b2b_accept_in_done", t2, td);
    wait_until(td2 + 2);

    // Abort in RUN after 5 samples; start and abort together in IDLE is accepted
    start_xfer(1'b1, 1'b0, 2, 12, 1'b0, 1'b1, t, td);
    e5 = 9;
    c  = t + 1 + e5 * 3 + 1;
    wait_until(c);
    i_abort = 1'b1;
    while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_sclk_cpol", o_sclk, 1);
    chk("abort_ready", o_start_ready, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_bit_idx", o_bit_idx, 5);
    repeat (8) @(negedge i_clk);

    // Randomized transfers
    for (int i = 0; i < 10; i++) begin
      rc = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      start_xfer(rc, rp, $urandom_range(0, 4), $urandom_range(0, 40), 1'b0, 1'($urandom_range(0, 1)), t, td);
      wait_until(td + $urandom_range(0, 2));
    end

    // Reset mid-RUN with CPOL=1
    start_xfer(1'b1, 1'b1, 1, 10, 1'b0, 1'b0, t, td);
    i_cpol = 1'b1;
    wait_until(t + 10);
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("reset_midrun_outputs",
        {o_sclk, o_busy, o_start_ready, o_lead_edge, o_trail_edge, o_shift, o_sample, o_done, o_bit_idx}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_reset_sclk", o_sclk, 1);
    repeat (6) @(negedge i_clk);

    chk("leftover_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
